// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman
// array controller.
package sw_pkg;

  typedef logic [1:0] nt_t;

  localparam nt_t NT_A = 2'b00;
  localparam nt_t NT_G = 2'b01;
  localparam nt_t NT_T = 2'b10;
  localparam nt_t NT_C = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_Q,
    S_ARR_RST,
    S_SETTLE,
    S_WAIT_DB,
    S_STREAM,
    S_DRAIN,
    S_ABORT,
    S_DONE
  } state_e;

  function automatic int unsigned neutral_score(
    input int unsigned width
  );
    return 32'd1 << (width - 1);
  endfunction

  function automatic int unsigned drain_timeout(
    input int unsigned n_pe
  );
    return 2 * n_pe + 4;
  endfunction

endpackage

// File: rtl/sw_preload_shreg.sv
// Query shift register; the first char shifted in
// ends up at PE 0 after N_PE shifts.
module sw_preload_shreg
  import sw_pkg::*;
#(
  parameter int N_PE = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              clr,
  input  logic              en,
  input  nt_t               din,
  output logic [2*N_PE-1:0] q
);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[2*N_PE-1:2]};
    end
  end

endmodule

// File: rtl/sw_array_ctrl.sv
// Job sequencer for a linear Smith-Waterman PE chain:
// query preload, array reset, db stream, drain, result.
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int N_PE        = 16,
  parameter int SCORE_WIDTH = 11,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_local,
  input  logic [LEN_WIDTH-1:0]   i_db_len,
  input  logic [1:0]             i_q_data,
  input  logic                   i_q_vld,
  output logic                   o_q_rdy,
  input  logic [1:0]             i_db_data,
  input  logic                   i_db_vld,
  output logic                   o_db_rdy,
  output logic                   o_arr_rst,
  output logic [1:0]             o_arr_data,
  output logic                   o_arr_vld,
  output logic                   o_arr_local,
  output logic [SCORE_WIDTH-1:0] o_arr_left_m,
  output logic [SCORE_WIDTH-1:0] o_arr_left_i,
  output logic [SCORE_WIDTH-1:0] o_arr_high,
  output logic [2*N_PE-1:0]      o_preload,
  input  logic [SCORE_WIDTH-1:0] i_arr_high,
  input  logic                   i_arr_vld,
  output logic                   o_res_vld,
  input  logic                   i_res_rdy,
  output logic [SCORE_WIDTH-1:0] o_score,
  output logic                   o_err,
  output logic                   o_busy
);

  localparam logic [SCORE_WIDTH-1:0] NEUTRAL =
    SCORE_WIDTH'(neutral_score(SCORE_WIDTH));
  localparam int DRAIN_TO = int'(drain_timeout(N_PE));
  localparam int TW       = $clog2(DRAIN_TO + 1);
  localparam int MSB      = SCORE_WIDTH - 1;

  localparam logic [TW-1:0] Q_LAST   = TW'(N_PE - 1);
  localparam logic [TW-1:0] RST_LAST = TW'(N_PE + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(DRAIN_TO - 1);
  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_e                 state, nxt;
  logic [LEN_WIDTH-1:0]   len_q, cnt;
  logic [TW-1:0]          tcnt;
  logic                   local_q, seen_q;
  logic                   arr_rst_q, arr_vld_q;
  nt_t                    arr_data_q;
  logic [SCORE_WIDTH-1:0] score_q;
  logic                   err_q;
  logic                   q_rdy, db_rdy;
  logic                   q_acc, db_acc, accept;

  assign accept = (state == S_IDLE) && i_start;
  assign q_acc  = q_rdy && i_q_vld;
  assign db_acc = db_rdy && i_db_vld;

  sw_preload_shreg #(.N_PE(N_PE)) u_shreg (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .clr     (accept),
    .en      (q_acc),
    .din     (i_q_data),
    .q       (o_preload)
  );

  always_comb begin
    nxt    = state;
    q_rdy  = 1'b0;
    db_rdy = 1'b0;
    unique case (state)
      S_IDLE:    if (i_start) nxt = S_LOAD_Q;
      S_LOAD_Q: begin
        q_rdy = 1'b1;
        if (i_q_vld && tcnt == Q_LAST)
          nxt = S_ARR_RST;
      end
      S_ARR_RST: if (tcnt == RST_LAST) nxt = S_SETTLE;
      S_SETTLE:
        nxt = (len_q == '0) ? S_DONE : S_WAIT_DB;
      S_WAIT_DB: begin
        db_rdy = 1'b1;
        if (i_db_vld)
          nxt = (len_q == ONE) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        db_rdy = 1'b1;
        if (!i_db_vld)       nxt = S_ABORT;
        else if (cnt == ONE) nxt = S_DRAIN;
      end
      // completion is the falling edge of the last PE's valid
      S_DRAIN: begin
        if (seen_q && !i_arr_vld) nxt = S_DONE;
        else if (tcnt == TO_LAST) nxt = S_ABORT;
      end
      S_ABORT:   nxt = S_DONE;
      S_DONE:    if (i_res_rdy) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      local_q    <= 1'b0;
      seen_q     <= 1'b0;
      arr_rst_q  <= 1'b1;
      arr_vld_q  <= 1'b0;
      arr_data_q <= '0;
      score_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state     <= nxt;
      arr_rst_q <= (nxt == S_ARR_RST) ||
                   (nxt == S_ABORT);
      arr_vld_q <= db_acc;
      seen_q    <= (state == S_DRAIN) &&
                   (seen_q || i_arr_vld);
      if (db_acc) arr_data_q <= i_db_data;
      if (accept) begin
        local_q <= i_local;
        len_q   <= i_db_len;
      end
      if (db_acc)
        cnt <= ((state == S_WAIT_DB) ? len_q : cnt)
               - ONE;
      if (nxt != state)
        tcnt <= '0;
      else if (q_acc || state == S_ARR_RST ||
               state == S_DRAIN)
        tcnt <= tcnt + 1'b1;
      if (state == S_SETTLE && len_q == '0) begin
        score_q <= '0;
        err_q   <= 1'b0;
      end else if (state == S_DRAIN &&
                   nxt == S_DONE) begin
        score_q <= {~i_arr_high[MSB],
                    i_arr_high[MSB-1:0]};
        err_q   <= 1'b0;
      end else if (state == S_ABORT) begin
        score_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign o_q_rdy      = q_rdy;
  assign o_db_rdy     = db_rdy;
  assign o_arr_rst    = arr_rst_q;
  assign o_arr_data   = arr_data_q;
  assign o_arr_vld    = arr_vld_q;
  assign o_arr_local  = local_q;
  assign o_arr_left_m = NEUTRAL;
  assign o_arr_left_i = NEUTRAL;
  assign o_arr_high   = NEUTRAL;
  assign o_res_vld    = (state == S_DONE);
  assign o_score      = score_q;
  assign o_err        = err_q;
  assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Scoreboard bench for sw_array_ctrl with a behavioral
// 4-PE affine-gap array model.
module tb_sw_array_ctrl;
  import sw_pkg::*;

  localparam int NP  = 4;
  localparam int SW  = 11;
  localparam int LW  = 16;
  localparam int NEU = 1024;
  localparam int MATCH = 5;
  localparam int MISM  = -4;
  localparam int GO    = 10;
  localparam int GE    = 1;
  localparam int NEG   = -100000;

  localparam logic [7:0] Q_ACGT = {NT_T, NT_G, NT_C, NT_A};
  localparam logic [7:0] Q_TTTT = {NT_T, NT_T, NT_T, NT_T};

  logic clk = 1'b0;
  logic i_rst_n, i_start, i_local;
  logic [LW-1:0] i_db_len;
  logic [1:0] i_q_data, i_db_data;
  logic i_q_vld, i_db_vld, i_res_rdy;
  logic o_q_rdy, o_db_rdy, o_arr_rst, o_arr_vld;
  logic o_arr_local, o_res_vld, o_err, o_busy;
  logic [1:0] o_arr_data;
  logic [SW-1:0] o_arr_left_m, o_arr_left_i, o_arr_high;
  logic [SW-1:0] o_score, i_arr_high;
  logic [2*NP-1:0] o_preload;
  logic i_arr_vld;

  sw_array_ctrl #(
    .N_PE(NP), .SCORE_WIDTH(SW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_local(i_local), .i_db_len(i_db_len),
    .i_q_data(i_q_data), .i_q_vld(i_q_vld),
    .o_q_rdy(o_q_rdy), .i_db_data(i_db_data),
    .i_db_vld(i_db_vld), .o_db_rdy(o_db_rdy),
    .o_arr_rst(o_arr_rst), .o_arr_data(o_arr_data),
    .o_arr_vld(o_arr_vld), .o_arr_local(o_arr_local),
    .o_arr_left_m(o_arr_left_m),
    .o_arr_left_i(o_arr_left_i),
    .o_arr_high(o_arr_high), .o_preload(o_preload),
    .i_arr_high(i_arr_high), .i_arr_vld(i_arr_vld),
    .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy),
    .o_score(o_score), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_cnt = 0;

  typedef struct { int score; int err; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d",
               name, act, want);
    end
  endtask

  // behavioral PE chain: N_PE-cycle valid delay,
  // score = Gotoh DP over the chars received so far
  logic [1:0] rx[$];
  logic [3:0] vsr;
  int ssr[4];
  int cur;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int align(input logic [7:0] pre,
                               input bit loc);
    int h[5][17];
    int e[5][17];
    int f[5][17];
    int n, best, s;
    n = rx.size();
    if (n > 16) n = 16;
    best = 0;
    for (int i = 0; i <= 4; i++)
      for (int j = 0; j <= 16; j++) begin
        h[i][j] = 0; e[i][j] = NEG; f[i][j] = NEG;
      end
    if (!loc) begin
      for (int i = 1; i <= 4; i++)
        h[i][0] = -(GO + GE * (i - 1));
      for (int j = 1; j <= n; j++)
        h[0][j] = -(GO + GE * (j - 1));
    end
    for (int i = 1; i <= 4; i++)
      for (int j = 1; j <= n; j++) begin
        s = (pre[2*(i-1) +: 2] == rx[j-1]) ? MATCH : MISM;
        e[i][j] = max2(e[i][j-1] - GE, h[i][j-1] - GO);
        f[i][j] = max2(f[i-1][j] - GE, h[i-1][j] - GO);
        h[i][j] = max2(h[i-1][j-1] + s,
                       max2(e[i][j], f[i][j]));
        if (loc) h[i][j] = max2(h[i][j], 0);
        if (h[i][j] > best) best = h[i][j];
      end
    return loc ? best : h[4][n];
  endfunction

  always @(posedge clk) begin
    if (o_arr_rst === 1'b1) begin
      rx.delete();
      vsr = '0;
      cur = 0;
      for (int k = 0; k < 4; k++) ssr[k] = 0;
      i_arr_vld  <= 1'b0;
      i_arr_high <= SW'(NEU);
    end else begin
      if (o_arr_vld === 1'b1) begin
        rx.push_back(o_arr_data);
        cur = align(o_preload, o_arr_local);
      end
      vsr = {vsr[2:0], o_arr_vld === 1'b1};
      for (int k = 3; k > 0; k--) ssr[k] = ssr[k-1];
      ssr[0] = cur;
      i_arr_vld  <= vsr[3];
      i_arr_high <= SW'(NEU + ssr[3]);
    end
  end

  always @(negedge clk) if (o_arr_vld === 1'b1) vld_cnt++;

  // result monitor: pops on every completed handshake
  always @(negedge clk) begin
    exp_t e;
    if (i_rst_n === 1'b1 && o_res_vld === 1'b1 &&
        i_res_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("score", $signed(o_score), e.score);
        chk("err", o_err, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int sc, input int er);
    exp_t e;
    e.score = sc;
    e.err   = er;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals();
    chk("rst_q_rdy", o_q_rdy, 0);
    chk("rst_db_rdy", o_db_rdy, 0);
    chk("rst_arr_vld", o_arr_vld, 0);
    chk("rst_res_vld", o_res_vld, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_arr_rst", o_arr_rst, 1);
    chk("rst_arr_data", o_arr_data, 0);
    chk("rst_preload", o_preload, 0);
    chk("rst_score", o_score, 0);
    chk("rst_left_m", o_arr_left_m, NEU);
    chk("rst_left_i", o_arr_left_i, NEU);
    chk("rst_high", o_arr_high, NEU);
  endtask

  task automatic start_job(input bit loc, input int len,
                           input logic [7:0] q);
    int n;
    vld_cnt  = 0;
    i_start  = 1'b1;
    i_local  = loc;
    i_db_len = LW'(len);
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_q_vld  = 1'b1;
      i_q_data = q[2*k +: 2];
      n = 0;
      while (o_q_rdy !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      if (o_q_rdy !== 1'b1) chk("q_rdy_timeout", 0, 1);
      tick();
    end
    i_q_vld = 1'b0;
  endtask

  task automatic wait_db(output int rst_n, output int gap);
    int n = 0;
    rst_n = 0;
    gap   = 0;
    while (o_db_rdy !== 1'b1 && n < 40) begin
      if (o_arr_rst === 1'b1) rst_n++;
      else if (rst_n > 0)     gap++;
      tick();
      n++;
    end
    if (o_db_rdy !== 1'b1) chk("db_rdy_timeout", 0, 1);
  endtask

  task automatic stream(input logic [31:0] db,
                        input int n, input int pulse);
    for (int k = 0; k < n; k++) begin
      i_db_vld  = 1'b1;
      i_db_data = db[2*k +: 2];
      if (k == pulse) i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    i_db_vld = 1'b0;
  endtask

  task automatic collect(input bit stall, input int sc);
    int n = 0;
    i_res_rdy = !stall;
    while (o_res_vld !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    chk("res_vld", o_res_vld, 1);
    if (stall) begin
      for (int k = 0; k < 10; k++) begin
        chk("stall_vld", o_res_vld, 1);
        chk("stall_score", $signed(o_score), sc);
        tick();
      end
    end
    i_res_rdy = 1'b1;
    tick();
    i_res_rdy = 1'b0;
    chk("idle_after", o_busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int rn, gp, n;
    i_rst_n = 1'b0; i_start = 1'b0; i_local = 1'b0;
    i_db_len = '0; i_q_data = '0; i_q_vld = 1'b0;
    i_db_data = '0; i_db_vld = 1'b0; i_res_rdy = 1'b0;
    tick();
    tick();
    check_reset_vals();
    i_rst_n = 1'b1;
    tick();

    // local ACGT vs ACGT
    sb_push(20, 0);
    start_job(1'b1, 4, Q_ACGT);
    wait_db(rn, gp);
    chk("arr_rst_cycles", rn, 6);
    chk("settle_gap", gp, 1);
    stream(32'(Q_ACGT), 4, -1);
    collect(1'b0, 0);
    chk("arr_vld_count", vld_cnt, 4);
    chk("preload_hold", o_preload, Q_ACGT);
    chk("arr_local", o_arr_local, 1);

    // local and global ACGT vs TTTT
    sb_push(5, 0);
    start_job(1'b1, 4, Q_ACGT);
    wait_db(rn, gp);
    stream(32'(Q_TTTT), 4, -1);
    collect(1'b0, 0);
    sb_push(-7, 0);
    start_job(1'b0, 4, Q_ACGT);
    wait_db(rn, gp);
    stream(32'(Q_TTTT), 4, -1);
    collect(1'b0, 0);
    chk("arr_local_g", o_arr_local, 0);

    // single-char database
    sb_push(5, 0);
    start_job(1'b1, 1, Q_ACGT);
    wait_db(rn, gp);
    stream(32'(NT_C), 1, -1);
    collect(1'b0, 0);
    chk("arr_vld_count1", vld_cnt, 1);

    // underflow abort
    sb_push(0, 1);
    start_job(1'b1, 8, Q_ACGT);
    wait_db(rn, gp);
    stream(32'(Q_ACGT), 3, -1);
    rn = 0;
    n  = 0;
    while (o_res_vld !== 1'b1 && n < 30) begin
      if (o_arr_rst === 1'b1) rn++;
      tick();
      n++;
    end
    chk("abort_rst_pulse", rn, 1);
    collect(1'b0, 0);

    // empty database
    sb_push(0, 0);
    start_job(1'b1, 0, Q_ACGT);
    collect(1'b0, 0);
    chk("arr_vld_count0", vld_cnt, 0);

    // start during stream, result stalled
    sb_push(20, 0);
    start_job(1'b1, 4, Q_ACGT);
    wait_db(rn, gp);
    stream(32'(Q_ACGT), 4, 2);
    collect(1'b1, 20);
    tick();
    tick();
    chk("no_second_job", o_busy, 0);

    // reset mid-stream, then clean rerun
    start_job(1'b1, 4, Q_ACGT);
    wait_db(rn, gp);
    stream(32'(Q_ACGT), 2, -1);
    i_rst_n  = 1'b0;
    i_db_vld = 1'b0;
    tick();
    check_reset_vals();
    i_rst_n = 1'b1;
    tick();
    sb_push(20, 0);
    start_job(1'b1, 4, Q_ACGT);
    wait_db(rn, gp);
    stream(32'(Q_ACGT), 4, -1);
    collect(1'b0, 0);

    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
